cp_inserter: RTL
================

Name: cp_inserter

Overview:
- Downstream stage of the inverse FFT. It takes the 32-point time-domain frame that the IFFT emits, one complex sample per valid cycle.
- It prepends a cyclic prefix: the last CP_LEN samples of the frame, repeated ahead of it.
- It emits the extended frame over a valid/ready stream toward the DAC/transmit path.
- Ping-pong frame banks let one frame be captured while the previous one drains.

Parameters:
N, 32, frame length in complex samples; power of two, matches the IFFT size.
CP_LEN, 8, prefix length; 1 <= CP_LEN < N.
W, 16, sample width per real/imag component, two's complement.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
data_real_in  input  W  IFFT output real part, signed.
data_imag_in  input  W  IFFT output imaginary part, signed.
in_valid  input  1  qualifies the input sample. There is no backpressure toward the IFFT.
data_real_out  output  W  output real part, signed.
data_imag_out  output  W  output imaginary part, signed.
out_valid  output  1  output sample valid.
out_ready  input  1  downstream accepts the sample when out_valid && out_ready.
out_sof  output  1  high with the first prefix sample of each output frame.
out_eof  output  1  high with the last body sample (index N-1).
overflow  output  1  sticky frame-drop flag; cleared only by reset.

Behaviour:
- Reset (async assert):
  - Outputs: all data outputs 0; out_valid, out_sof, out_eof, overflow all 0.
  - Internal state: write pointer 0, write bank 0, both bank-full flags 0, read FSM in IDLE.
- Write side:
  - Each in_valid cycle writes the sample to bank wr_bank at address wr_idx, then increments wr_idx.
  - Frame boundary is implicit: a sample with wr_idx==0 starts a frame.
  - At wr_idx==N-1 the sample is written, full[wr_bank] is set, wr_bank toggles and wr_idx wraps to 0.
- Drop rule:
  - If in_valid arrives with wr_idx==0 and full[wr_bank]==1, the whole frame is discarded: N valid samples are counted but not written, and overflow is set.
  - The drop decision is made only on the first sample of the frame.
  - A bank released in the same cycle counts as still full; its full flag clears on the next edge.
- Read FSM, states IDLE, PREFIX, BODY:
  - IDLE: when full[rd_bank] is seen, load rd_idx = N-CP_LEN and go to PREFIX. The first out_valid appears on the following edge, registered.
  - Minimum latency: the last input sample is at edge t, full is set at t, and out_valid rises at t+2.
  - PREFIX: on each handshake rd_idx increments. After the handshake at rd_idx==N-1, rd_idx wraps to 0 and the FSM goes to BODY.
  - BODY: on each handshake rd_idx increments. The handshake at rd_idx==N-1 clears full[rd_bank] and toggles rd_bank.
  - After that last body sample the FSM goes back to PREFIX with no bubble if the other bank is already full; otherwise it goes to IDLE and out_valid drops.
- Output stream:
  - Each frame emits exactly N+CP_LEN samples, in index order N-CP_LEN..N-1 followed by 0..N-1.
  - Output registers hold value, out_sof and out_eof stable while out_valid && !out_ready; out_valid never drops without a handshake.
  - out_sof is asserted only on the first prefix sample and out_eof only on body index N-1. They are mutually exclusive since CP_LEN < N.
- Data path: samples pass bit-exact with no scaling or rounding, sign preserved; -32768 is preserved.
- Reset mid-operation: a partial input frame and any pending output are abandoned; after release, the next valid sample is index 0 of a new frame.
- Throughput limit: sustained input must average at most N in-valid cycles per N+CP_LEN cycles. Exceeding this drops frames per the drop rule and never corrupts a frame already in a bank.

Decomposition:
- Shared package cp_pkg holds:
  - N, CP_LEN, W defaults;
  - log2 address width;
  - read FSM enum {IDLE, PREFIX, BODY};
  - a complex sample struct {real, imag}.
- One sub-module, cp_bank_ram: 2 x N x 2W register array with one write port and one combinational read port, addressed by {bank, idx}.
- The FSM and counters live in the top level.

Test Plan:
1. Single frame, in_valid=1 for 32 cycles with real=k, imag=-k for k=0..31, out_ready=1 -> 40 outputs real = 24..31 then 0..31, imag negated; out_sof on the first, out_eof on the last; out_valid first high 2 edges after the 32nd input.
2. Same frame with out_ready toggling 1,0,1,0 -> identical 40-sample sequence; data, out_sof and out_eof held constant during every stall.
3. Continuous in_valid for 96 cycles, 3 frames, out_ready=1 -> frames 1 and 2 output back-to-back with no bubble; frame 3 dropped; overflow=1 and stays 1.
4. Three frames separated by 8 idle cycles each, out_ready=1 -> 120 output samples, all frames correct, overflow=0.
5. Frame with samples at +32767/-32768 extremes -> output values bit-exact.
6. Assert reset after 20 samples of input and again during output PREFIX -> all outputs 0 immediately; the next 32-sample frame outputs correctly starting at index 24.

Source files
------------

// File: rtl/cp_pkg.sv
// -----------------------------------------------------------------------------
// cp_pkg
// Shared constants and types for the cyclic-prefix inserter.
//   N       : frame length in complex samples (power of two, IFFT size)
//   CP_LEN  : cyclic prefix length, 1 <= CP_LEN < N
//   W       : width of each real/imag component, two's complement
// To retarget the block to another FFT size, change the constants here.
// -----------------------------------------------------------------------------
package cp_pkg;

    localparam int N      = 32;
    localparam int CP_LEN = 8;
    localparam int W      = 16;
    localparam int AW     = $clog2(N);

    // Frequently used index values
    localparam logic [AW-1:0] IDX_ZERO = AW'(0);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [AW-1:0] IDX_CP   = AW'(N - CP_LEN);

    // Read-side sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        BODY   = 2'd2
    } rd_state_e;

    // One complex sample; fields are raw two's-complement bits
    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } cplx_t;

    // Flat RAM address: bank select in the MSB, sample index below it
    function automatic logic [AW:0] bank_addr(input logic bank, input logic [AW-1:0] idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/cp_bank_ram.sv
// -----------------------------------------------------------------------------
// cp_bank_ram
// Two frame banks of N complex samples each, held in a register array.
// One synchronous write port and one combinational read port, both addressed
// by {bank, idx}.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address {bank, idx}
//   wr_data_i  : sample to store
//   rd_addr_i  : read address {bank, idx}
//   rd_data_o  : sample at rd_addr_i (combinational)
// The array carries no reset: a bank is only read after it has been filled.
// -----------------------------------------------------------------------------
module cp_bank_ram
    import cp_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW:0]   wr_addr_i,
    input  cplx_t         wr_data_i,
    input  logic [AW:0]   rd_addr_i,
    output cplx_t         rd_data_o
);

    cplx_t mem_q [2*N];

    // Sample storage write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cp_inserter.sv
// -----------------------------------------------------------------------------
// cp_inserter
// Captures 32-sample IFFT frames into ping-pong banks and re-emits each frame
// with a cyclic prefix (its last CP_LEN samples) in front of it, over a
// valid/ready stream.
//   clk, reset                   : clock, asynchronous active-high reset
//   data_real_in/data_imag_in    : input sample, qualified by in_valid
//   in_valid                     : input strobe, no backpressure
//   data_real_out/data_imag_out  : output sample, qualified by out_valid
//   out_valid / out_ready        : output handshake
//   out_sof                      : first prefix sample of a frame
//   out_eof                      : last body sample of a frame
//   overflow                     : sticky, set when an input frame is dropped
// -----------------------------------------------------------------------------
module cp_inserter
    import cp_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  data_real_in,
    input  logic [W-1:0]  data_imag_in,
    input  logic          in_valid,
    output logic [W-1:0]  data_real_out,
    output logic [W-1:0]  data_imag_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic          out_eof,
    output logic          overflow
);

    // Write side state
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          drop_q, drop_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          frame_drop_s;
    logic          wr_en_s;
    logic          set_full_s;

    // Read side state
    rd_state_e     state_q, state_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          rd_bank_q, rd_bank_d;
    logic          hs_s;
    logic          load_s;
    logic          rel_s;

    // Output registers
    cplx_t         dout_q;
    logic          valid_q;
    logic          sof_q;
    logic          eof_q;

    cplx_t         wr_data_s;
    cplx_t         rd_data_s;

    assign wr_data_s = '{re: data_real_in, im: data_imag_in};

    cp_bank_ram u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (bank_addr(wr_bank_q, wr_idx_q)),
        .wr_data_i (wr_data_s),
        .rd_addr_i (bank_addr(rd_bank_d, rd_idx_d)),
        .rd_data_o (rd_data_s)
    );

    // Write pointer, drop decision and bank-full bookkeeping
    always_comb begin
        wr_idx_d   = wr_idx_q;
        wr_bank_d  = wr_bank_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        wr_en_s    = 1'b0;
        set_full_s = 1'b0;
        // The drop decision is taken on the first sample and then held for the frame.
        frame_drop_s = (wr_idx_q == IDX_ZERO) ? full_q[wr_bank_q] : drop_q;
        if (in_valid) begin
            drop_d  = frame_drop_s;
            wr_en_s = !frame_drop_s;
            if (frame_drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            if (wr_idx_q == IDX_LAST) begin
                wr_idx_d = IDX_ZERO;
                if (!frame_drop_s) begin
                    wr_bank_d  = ~wr_bank_q;
                    set_full_s = 1'b1;
                end else begin
                    wr_bank_d  = wr_bank_q;
                    set_full_s = 1'b0;
                end
            end else begin
                wr_idx_d = wr_idx_q + IDX_ONE;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        full_d = full_q;
        if (rel_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d = full_q;
        end
        // The writer never targets the bank being released, so the order is safe.
        if (set_full_s) begin
            full_d[wr_bank_q] = 1'b1;
        end else begin
            full_d = full_d;
        end
    end

    // Read sequencing: IDLE -> PREFIX (N-CP_LEN..N-1) -> BODY (0..N-1)
    always_comb begin
        hs_s      = valid_q && out_ready;
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        rel_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = PREFIX;
                    rd_idx_d = IDX_CP;
                end else begin
                    state_d  = IDLE;
                end
            end
            PREFIX: begin
                if (hs_s) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d = IDX_ZERO;
                        state_d  = BODY;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_ONE;
                    end
                end else begin
                    rd_idx_d = rd_idx_q;
                end
            end
            BODY: begin
                if (hs_s) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rel_s     = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_idx_d  = IDX_CP;
                        // Chain straight into the next frame when it is already waiting.
                        if (full_q[~rd_bank_q]) begin
                            state_d = PREFIX;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_ONE;
                    end
                end else begin
                    rd_idx_d = rd_idx_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The RAM is addressed with the next pointer, so the output register
        // always holds the sample that rd_idx_q/state_q describe. The cycle
        // right after leaving IDLE fills the empty output register.
        load_s = (state_q != IDLE) && (!valid_q || hs_s) && (state_d != IDLE);
    end

    // Write-side registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_q   <= IDX_ZERO;
            wr_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            wr_bank_q  <= wr_bank_d;
            drop_q     <= drop_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Read FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_idx_q  <= IDX_ZERO;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Output stage: load on an empty slot or a handshake, hold during a stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '{re: {W{1'b0}}, im: {W{1'b0}}};
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (load_s) begin
            dout_q  <= rd_data_s;
            valid_q <= 1'b1;
            sof_q   <= (state_d == PREFIX) && (rd_idx_d == IDX_CP);
            eof_q   <= (state_d == BODY) && (rd_idx_d == IDX_LAST);
        end else if (hs_s) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            valid_q <= valid_q;
            sof_q   <= sof_q;
            eof_q   <= eof_q;
        end
    end

    assign data_real_out = dout_q.re;
    assign data_imag_out = dout_q.im;
    assign out_valid     = valid_q;
    assign out_sof       = sof_q;
    assign out_eof       = eof_q;
    assign overflow      = overflow_q;

endmodule
